nx_instr_store_multi: RTL

// - Parametrised successor to the dual-core instruction store: serves CORES independent cores per node.
// - Each core has a private bank of MAX_INSTRS entries, filled in order by the node's load path via a

---
 rtl/nx_instr_pkg.sv | 23 ++
 rtl/nx_instr_store_multi_if.sv | 30 +++
 rtl/nx_instr_bank.sv | 75 +++++++
 rtl/nx_ram.sv | 43 ++++
 rtl/nx_instr_store_multi.sv | 85 ++++++++
 5 files changed

// File: rtl/nx_instr_pkg.sv
// -----------------------------------------------------------------------------
// nx_instr_pkg
// Shared types and helpers for the multi-core instruction store.
//   MAX_CORES      largest supported number of cores per node
//   instr_addr_t   bank address in the standard 512-entry configuration
//   instr_count_t  populated count in the standard 512-entry configuration
//   core_idx_t     wide enough to name any core up to MAX_CORES
//   idx_width()    width of a core index, never narrower than one bit
// -----------------------------------------------------------------------------
package nx_instr_pkg;

    localparam int MAX_CORES      = 8;
    localparam int DEF_MAX_INSTRS = 512;

    typedef logic [$clog2(DEF_MAX_INSTRS)-1:0] instr_addr_t;
    typedef logic [$clog2(DEF_MAX_INSTRS):0]   instr_count_t;
    typedef logic [$clog2(MAX_CORES)-1:0]      core_idx_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nx_instr_store_multi_if.sv
// -----------------------------------------------------------------------------
// nx_instr_store_multi_if
// Store path from the node loader into the instruction store.
//   store_core   target core of the store
//   store_data   instruction word to append
//   store_valid  store request
//   store_ready  store accepted when valid && ready
//   store_err    sticky flag: a store addressed a core that does not exist
// master = node loader, slave = instruction store.
// -----------------------------------------------------------------------------
interface nx_instr_store_multi_if #(
    parameter int CW = 1,
    parameter int DW = 15
);
    logic [CW-1:0] store_core;
    logic [DW-1:0] store_data;
    logic          store_valid;
    logic          store_ready;
    logic          store_err;

    modport master (
        output store_core, store_data, store_valid,
        input  store_ready, store_err
    );

    modport slave (
        input  store_core, store_data, store_valid,
        output store_ready, store_err
    );
endinterface

// File: rtl/nx_instr_bank.sv
// -----------------------------------------------------------------------------
// nx_instr_bank
// Private instruction bank of one core: RAM, populated counter, full flag,
// clear handling and the read-valid pulse.
//   i_wr         accepted store to this core (top guarantees bank not full)
//   i_wdata      word to append at address populated
//   i_clear      reset populated to 0 next edge, contents kept
//   i_rd/i_addr  fetch request and address
//   o_populated  number of loaded words, 0..MAX_INSTRS
//   o_full       populated == MAX_INSTRS
//   o_stall      fetch refused this cycle (store or clear owns the bank)
//   o_data       fetched word, one cycle after an accepted read
//   o_valid      single-cycle pulse marking o_data updated
// -----------------------------------------------------------------------------
module nx_instr_bank #(
    parameter  int INSTR_WIDTH = 15,
    parameter  int MAX_INSTRS  = 512,
    localparam int AW          = $clog2(MAX_INSTRS),
    localparam int PW          = AW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_wr,
    input  logic [INSTR_WIDTH-1:0] i_wdata,
    input  logic                   i_clear,
    input  logic                   i_rd,
    input  logic [AW-1:0]          i_addr,
    output logic [PW-1:0]          o_populated,
    output logic                   o_full,
    output logic                   o_stall,
    output logic [INSTR_WIDTH-1:0] o_data,
    output logic                   o_valid
);
    logic [PW-1:0] r_populated;
    logic          r_valid;
    logic          w_rd_acc;
    logic [AW-1:0] w_ram_addr;

    assign o_stall    = i_wr || i_clear;
    assign w_rd_acc   = i_rd && !o_stall;
    // Appends go to the next free slot; the low AW bits suffice because a
    // full bank never receives a write.
    assign w_ram_addr = i_wr ? r_populated[AW-1:0] : i_addr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_populated <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (i_clear) begin
                r_populated <= '0;
            end else if (i_wr) begin
                r_populated <= r_populated + PW'(1);
            end
        end
    end

    nx_ram #(
        .DW    (INSTR_WIDTH),
        .DEPTH (MAX_INSTRS)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (i_wr),
        .i_re    (w_rd_acc),
        .i_addr  (w_ram_addr),
        .i_wdata (i_wdata),
        .o_rdata (o_data)
    );

    assign o_populated = r_populated;
    assign o_full      = (r_populated == PW'(MAX_INSTRS));
    assign o_valid     = r_valid;
endmodule

// File: rtl/nx_ram.sv
// -----------------------------------------------------------------------------
// nx_ram
// Single-port RAM with a registered read port. A write in the same cycle as
// a read wins; the read is simply not performed.
//   clk_i, rst_ni  clock, asynchronous active-low reset (read register only)
//   i_we, i_re     write / read enable
//   i_addr         shared address
//   i_wdata        write data
//   o_rdata        read data, updated the cycle after a read, held otherwise
// -----------------------------------------------------------------------------
module nx_ram #(
    parameter  int DW    = 15,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Array is left unreset so it can map onto block RAM.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (i_re && !i_we) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/nx_instr_store_multi.sv
// -----------------------------------------------------------------------------
// nx_instr_store_multi
// Instruction store serving CORES cores, each with a private bank filled in
// order through one node-wide store port.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   store_if        store handshake (core, data, valid, ready, sticky err)
//   clear_i         per-core clear of the populated count
//   populated_o     per-core populated count, PW bits each
//   full_o          per-core bank full
//   core_addr_i     per-core fetch address, AW bits each
//   core_rd_i       per-core fetch request
//   core_stall_o    per-core fetch refused this cycle
//   core_data_o     per-core fetched word
//   core_valid_o    per-core pulse: core_data_o updated
// -----------------------------------------------------------------------------
module nx_instr_store_multi
    import nx_instr_pkg::*;
#(
    parameter  int CORES       = 2,
    parameter  int INSTR_WIDTH = 15,
    parameter  int MAX_INSTRS  = 512,
    localparam int AW          = $clog2(MAX_INSTRS),
    localparam int CW          = idx_width(CORES),
    localparam int PW          = AW + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    nx_instr_store_multi_if.slave        store_if,
    input  logic [CORES-1:0]             clear_i,
    output logic [CORES*PW-1:0]          populated_o,
    output logic [CORES-1:0]             full_o,
    input  logic [CORES*AW-1:0]          core_addr_i,
    input  logic [CORES-1:0]             core_rd_i,
    output logic [CORES-1:0]             core_stall_o,
    output logic [CORES*INSTR_WIDTH-1:0] core_data_o,
    output logic [CORES-1:0]             core_valid_o
);
    logic [CORES-1:0] w_sel;
    logic [CORES-1:0] w_wr;
    logic             w_in_range;
    logic             w_blocked;
    logic             w_accept;
    logic             r_err;

    for (genvar c = 0; c < CORES; c++) begin : g_core
        // One-hot decode; an index with no matching core leaves w_sel empty.
        assign w_sel[c] = (store_if.store_core == CW'(c));
        assign w_wr[c]  = w_accept && w_sel[c];

        nx_instr_bank #(
            .INSTR_WIDTH (INSTR_WIDTH),
            .MAX_INSTRS  (MAX_INSTRS)
        ) u_bank (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .i_wr        (w_wr[c]),
            .i_wdata     (store_if.store_data),
            .i_clear     (clear_i[c]),
            .i_rd        (core_rd_i[c]),
            .i_addr      (core_addr_i[c*AW +: AW]),
            .o_populated (populated_o[c*PW +: PW]),
            .o_full      (full_o[c]),
            .o_stall     (core_stall_o[c]),
            .o_data      (core_data_o[c*INSTR_WIDTH +: INSTR_WIDTH]),
            .o_valid     (core_valid_o[c])
        );
    end

    // Out-of-range stores are always accepted so a bad loader cannot wedge
    // the port; they are dropped and flagged instead.
    assign w_in_range           = |w_sel;
    assign w_blocked            = |(w_sel & (full_o | clear_i));
    assign store_if.store_ready = !w_blocked;
    assign w_accept             = store_if.store_valid && !w_blocked;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign store_if.store_err = r_err;
endmodule
